// File: rtl/alu_sw_console.sv
// Board-level ALU console: switch operands, debounced buttons, direct or
// single-button sequenced entry, registered result and flags on the LEDs.
module alu_sw_console #(
  parameter int N_BITS          = 6,
  parameter int N_LEDS          = 6,
  parameter int N_B             = 3,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_BITS-1:0] i_SWs,
  input  logic [N_B-1:0]    i_buttons,
  input  logic              i_mode,
  output logic [N_LEDS-1:0] o_led,
  output logic [2:0]        o_flags,
  output logic [1:0]        o_state,
  output logic              o_valid
);

  // state  | meaning
  // S_A    | next ENTER loads operand A
  // S_B    | next ENTER loads operand B
  // S_OP   | next ENTER loads the opcode and marks the result valid
  // S_SHOW | result shown; next ENTER restarts entry (also held in direct mode)
  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_OP   = 2'd2,
    S_SHOW = 2'd3
  } state_t;

  localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int MSB = N_BITS - 1;

  localparam logic [N_BITS-1:0] OP_ADD = N_BITS'(6'b100000);
  localparam logic [N_BITS-1:0] OP_SUB = N_BITS'(6'b100010);
  localparam logic [N_BITS-1:0] OP_AND = N_BITS'(6'b100100);
  localparam logic [N_BITS-1:0] OP_OR  = N_BITS'(6'b100101);
  localparam logic [N_BITS-1:0] OP_XOR = N_BITS'(6'b100110);
  localparam logic [N_BITS-1:0] OP_NOR = N_BITS'(6'b100111);
  localparam logic [N_BITS-1:0] OP_SRA = N_BITS'(6'b000011);
  localparam logic [N_BITS-1:0] OP_SRL = N_BITS'(6'b000010);

  logic [N_B-1:0] sync1_q, sync2_q;
  logic [N_B-1:0] pulse_q, pulse_d;
  logic [CW-1:0]  cnt_q [N_B];
  logic [CW-1:0]  cnt_d [N_B];

  // Counter saturates at the threshold so a held button yields a single pulse.
  always_comb begin
    for (int i = 0; i < N_B; i++) begin
      cnt_d[i]   = '0;
      pulse_d[i] = 1'b0;
      if (sync2_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES)) begin
          cnt_d[i] = cnt_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
        pulse_d[i] = (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1));
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      pulse_q <= '0;
      for (int i = 0; i < N_B; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= i_buttons;
      sync2_q <= sync1_q;
      pulse_q <= pulse_d;
      for (int i = 0; i < N_B; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  state_t            state_q, state_d;
  logic              mode_q;
  logic [N_BITS-1:0] a_q, b_q, op_q;
  logic [2:0]        seen_q, seen_d;
  logic              valid_q, valid_d;
  logic              ld_a, ld_b, ld_op, seq_valid;

  always_comb begin
    state_d   = state_q;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    ld_op     = 1'b0;
    seq_valid = 1'b0;
    if (!i_mode) begin
      state_d = S_SHOW;
      ld_a    = pulse_q[2];
      ld_b    = pulse_q[1];
      ld_op   = pulse_q[0];
    end else if (!mode_q) begin
      // Entering sequenced mode always restarts entry; a coincident ENTER is dropped.
      state_d = S_A;
    end else if (pulse_q[0]) begin
      case (state_q)
        S_A: begin
          ld_a    = 1'b1;
          state_d = S_B;
        end
        S_B: begin
          ld_b    = 1'b1;
          state_d = S_OP;
        end
        S_OP: begin
          ld_op     = 1'b1;
          seq_valid = 1'b1;
          state_d   = S_SHOW;
        end
        default: state_d = S_A;
      endcase
    end
  end

  assign seen_d  = seen_q | {ld_a, ld_b, ld_op};
  assign valid_d = valid_q | seq_valid | (!i_mode && (&seen_d));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_A;
      mode_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      seen_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= i_mode;
      if (ld_a)  a_q  <= i_SWs;
      if (ld_b)  b_q  <= i_SWs;
      if (ld_op) op_q <= i_SWs;
      seen_q  <= seen_d;
      valid_q <= valid_d;
    end
  end

  logic [N_BITS:0]   sum_w, diff_w;
  logic [N_BITS-1:0] res;
  logic              carry, ovf, shift_big;

  assign sum_w     = {1'b0, a_q} + {1'b0, b_q};
  assign diff_w    = {1'b0, a_q} - {1'b0, b_q};
  assign shift_big = (32'(b_q) >= 32'(N_BITS));

  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op_q)
      OP_ADD: begin
        res   = sum_w[N_BITS-1:0];
        carry = sum_w[N_BITS];
        ovf   = (a_q[MSB] == b_q[MSB]) && (sum_w[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        res   = diff_w[N_BITS-1:0];
        carry = diff_w[N_BITS];
        ovf   = (a_q[MSB] != b_q[MSB]) && (diff_w[MSB] != a_q[MSB]);
      end
      OP_AND: res = a_q & b_q;
      OP_OR:  res = a_q | b_q;
      OP_XOR: res = a_q ^ b_q;
      OP_NOR: res = ~(a_q | b_q);
      OP_SRA: begin
        if (shift_big) res = {N_BITS{a_q[MSB]}};
        else           res = $signed(a_q) >>> b_q;
      end
      OP_SRL: begin
        if (shift_big) res = '0;
        else           res = a_q >> b_q;
      end
      default: res = '0;
    endcase
  end

  logic [N_LEDS-1:0] led_d;

  generate
    if (N_LEDS <= N_BITS) begin : g_led_trunc
      assign led_d = res[N_LEDS-1:0];
    end else begin : g_led_ext
      assign led_d = {{(N_LEDS - N_BITS){1'b0}}, res};
    end
  endgenerate

  logic [N_LEDS-1:0] led_q;
  logic [2:0]        flags_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      led_q   <= '0;
      flags_q <= '0;
    end else begin
      led_q   <= led_d;
      flags_q <= {(res == '0), carry, ovf};
    end
  end

  assign o_led   = led_q;
  assign o_flags = flags_q;
  assign o_state = state_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_alu_sw_console.sv
// Scoreboard bench for alu_sw_console: stimulus pushes cycle-stamped expected
// outputs computed by an arithmetic reference model; a monitor pops and compares.
module tb_alu_sw_console;

  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] i_SWs = '0;
  logic [2:0] i_buttons = '0;
  logic       i_mode = 1'b0;
  logic [5:0] o_led;
  logic [2:0] o_flags;
  logic [1:0] o_state;
  logic       o_valid;

  alu_sw_console #(
    .N_BITS(6), .N_LEDS(6), .N_B(3), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock(clock), .reset(reset), .i_SWs(i_SWs), .i_buttons(i_buttons),
    .i_mode(i_mode), .o_led(o_led), .o_flags(o_flags), .o_state(o_state),
    .o_valid(o_valid)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [5:0] led;
    logic [2:0] flags;
    logic       valid;
    logic [1:0] state;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  int mA = 0, mB = 0, mOP = 0, mstate = 0;
  bit mvalid = 0;
  bit [2:0] mseen = '0;

  function automatic int sgn(int v);
    return (v >= 32) ? v - 64 : v;
  endfunction

  // Returns {result[5:0], zero, carry, overflow}
  function automatic logic [8:0] ref_alu(int a, int b, int op);
    int r, t;
    bit c, v;
    r = 0; c = 0; v = 0;
    case (op)
      32: begin r = (a + b) % 64; c = (a + b) >= 64;
                t = sgn(a) + sgn(b); v = (t > 31) || (t < -32); end
      34: begin r = (a - b + 64) % 64; c = a < b;
                t = sgn(a) - sgn(b); v = (t > 31) || (t < -32); end
      36: r = a & b;
      37: r = a | b;
      38: r = a ^ b;
      39: r = ~(a | b) & 63;
      3:  r = (b >= 6) ? ((sgn(a) < 0) ? 63 : 0) : ((sgn(a) >>> b) & 63);
      2:  r = (b >= 6) ? 0 : (a >> b);
      default: r = 0;
    endcase
    return {6'(r), (r == 0), c, v};
  endfunction

  function automatic void apply_load(logic [2:0] mask, int sw);
    if (!i_mode) begin
      if (mask[2]) mA = sw;
      if (mask[1]) mB = sw;
      if (mask[0]) mOP = sw;
      mseen = mseen | mask;
      if (&mseen) mvalid = 1;
      mstate = 3;
    end else if (mask[0]) begin
      case (mstate)
        0: begin mA = sw; mseen[2] = 1; mstate = 1; end
        1: begin mB = sw; mseen[1] = 1; mstate = 2; end
        2: begin mOP = sw; mseen[0] = 1; mvalid = 1; mstate = 3; end
        default: mstate = 0;
      endcase
    end
  endfunction

  function automatic void push(int c, logic [8:0] r);
    exp_t e;
    e.cyc = c; e.led = r[8:3]; e.flags = r[2:0];
    e.valid = mvalid; e.state = 2'(mstate);
    q.push_back(e);
  endfunction

  task automatic check(string nm, int c, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, c, got, want);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc < cyc) begin
        check("schedule", e.cyc, cyc, e.cyc);
      end else begin
        check("led",   cyc, int'(o_led),   int'(e.led));
        check("flags", cyc, int'(o_flags), int'(e.flags));
        check("valid", cyc, int'(o_valid), int'(e.valid));
        check("state", cyc, int'(o_state), int'(e.state));
      end
    end
  end

  task automatic do_reset();
    int c;
    @(negedge clock);
    reset = 1'b1; c = cyc;
    mA = 0; mB = 0; mOP = 0; mvalid = 0; mseen = '0; mstate = 0;
    push(c + 1, 9'b0);
    mstate = i_mode ? 0 : 3;
    push(c + 2, ref_alu(0, 0, 0));
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic set_mode(input logic m);
    int c;
    @(negedge clock);
    i_mode = m; c = cyc;
    mstate = m ? 0 : 3;
    push(c + 2, ref_alu(mA, mB, mOP));
    repeat (3) @(negedge clock);
  endtask

  task automatic press(input logic [2:0] mask, input int sw, input int len);
    int c, last;
    logic [8:0] before_r, after_r;
    @(negedge clock);
    i_SWs = 6'(sw); i_buttons = mask; c = cyc;
    before_r = ref_alu(mA, mB, mOP);
    if (len > D) apply_load(mask, sw);
    after_r = ref_alu(mA, mB, mOP);
    last = (c + D + 5 > c + len + 5) ? c + D + 5 : c + len + 5;
    push(c + D + 3, before_r);
    push(c + D + 4, after_r);
    push(last, after_r);
    repeat (len - 1) @(negedge clock);
    i_buttons = '0;
    while (cyc < c + D + 3) @(negedge clock);
    i_SWs = 6'($urandom);
    while (cyc < last) @(negedge clock);
  endtask

  int ops[8] = '{32, 34, 36, 37, 38, 39, 3, 2};

  task automatic rand_press();
    logic [2:0] mask;
    int sw, len;
    mask = 3'($urandom_range(1, 7));
    sw = (mask[0] && $urandom_range(0, 4) != 0) ? ops[$urandom_range(0, 7)]
                                                : $urandom_range(0, 63);
    len = ($urandom_range(0, 5) == 0) ? $urandom_range(1, D) : $urandom_range(D + 1, D + 6);
    press(mask, sw, len);
  endtask

  initial begin
    do_reset();
    // Direct mode basics
    press(3'b100, 12, 6); press(3'b010, 5, 6); press(3'b001, 32, 6);
    press(3'b100, 5, 6);  press(3'b010, 12, 6); press(3'b001, 34, 6);
    press(3'b100, 31, 6); press(3'b010, 1, 6);  press(3'b001, 32, 6);
    // Shifts and unknown opcode
    press(3'b100, 36, 6); press(3'b010, 2, 6);  press(3'b001, 3, 6);
    press(3'b001, 2, 6);  press(3'b010, 7, 6);  press(3'b001, 3, 6);
    press(3'b001, 2, 6);  press(3'b001, 63, 6);
    // Glitch and long hold
    press(3'b010, 9, 3);
    press(3'b010, 9, 50);
    repeat (20) rand_press();
    // Sequenced entry from a fresh reset
    do_reset();
    set_mode(1'b1);
    press(3'b001, 3, 6);
    press(3'b110, $urandom_range(0, 63), 6);
    press(3'b001, 4, 6);
    press(3'b110, $urandom_range(0, 63), 6);
    press(3'b001, 36, 6);
    press(3'b001, 9, 6);
    // Reset in S_OP, then prove A and B were cleared
    press(3'b001, 7, 6); press(3'b001, 9, 6);
    do_reset();
    set_mode(1'b0);
    press(3'b001, 32, 6);
    set_mode(1'b1);
    repeat (12) rand_press();
    set_mode(1'b0);
    repeat (8) rand_press();
    begin
      int waited = 0;
      while (q.size() > 0 && waited < 100) begin
        @(negedge clock); waited++;
      end
      if (q.size() > 0) check("drain", cyc, q.size(), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog at cycle %0d: got timeout expected completion", cyc);
    $fatal(1);
  end

endmodule
